store_monitor: RTL and testbench
================================

STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning store-log FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter MATCH_ADDR, default 84, meaning the byte address of the pass store.
REQ-003 SHALL have parameter MATCH_DATA, default 32'h96, meaning the data value of the pass store.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the cycles allowed before fail.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic updates on posedge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port memWrite, input, 1 bit: CPU store strobe, sampled at posedge.
REQ-008 SHALL have port dataAddr, input, 32 bits: CPU store address.
REQ-009 SHALL have port writeData, input, 32 bits: CPU store data.
REQ-010 SHALL have port logValid, output, 1 bit: the FIFO head holds a logged store.
REQ-011 SHALL have port logReady, input, 1 bit: the consumer accepts the head entry.
REQ-012 SHALL have port logAddr, output, 32 bits: address of the head entry.
REQ-013 SHALL have port logData, output, 32 bits: data of the head entry.
REQ-014 SHALL have port pass, output, 1 bit: sticky flag, the matching store was observed.
REQ-015 SHALL have port fail, output, 1 bit: sticky flag, the timeout expired before a match.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, a store was dropped because the FIFO was full.
REQ-017 SHALL have port storeCount, output, 16 bits: total stores observed, saturating at 16'hFFFF.

Function
REQ-018 SHALL treat each posedge with memWrite=1 as exactly one store event, using dataAddr and writeData as sampled at that edge.
REQ-019 SHALL push {dataAddr, writeData} into the FIFO on a store event when the FIFO is not full; the entry is visible on logValid, logAddr and logData the next cycle (first-word-fall-through).
REQ-020 SHALL pop the FIFO head at a posedge where logValid=1 and logReady=1; logReady with logValid=0 has no effect.
REQ-021 SHALL push and pop in the same cycle when the FIFO is full and a pop occurs, so the occupancy is unchanged and no store is dropped.
REQ-022 SHALL drop a store that arrives while the FIFO is full with no pop, and set overflow=1 until reset.
REQ-023 SHALL hold logAddr and logData stable while logValid=1 and logReady=0.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-025 SHALL increment storeCount on every store event, including dropped ones, and saturate at 16'hFFFF.
REQ-026 SHALL implement the checker states WAIT, PASS and TIMEOUT; WAIT is entered on reset.
REQ-027 SHALL, in WAIT, increment a cycle counter every cycle.
REQ-028 SHALL, in WAIT, go to PASS on a store event with dataAddr==MATCH_ADDR and writeData==MATCH_DATA.
REQ-029 SHALL, in WAIT, go to TIMEOUT when the cycle counter reaches TIMEOUT_CYCLES-1.
REQ-030 SHALL give PASS priority when a match and the timeout occur in the same cycle.
REQ-031 SHALL treat PASS and TIMEOUT as terminal until reset; stores continue to be logged and counted in these states.
REQ-032 SHALL drive pass=1 exactly in PASS and fail=1 exactly in TIMEOUT, both registered, so each asserts one cycle after the deciding edge.

Reset
REQ-033 SHALL, while reset=0, immediately force: state=WAIT, FIFO empty, logValid=0, logAddr=0, logData=0, pass=0, fail=0, overflow=0, storeCount=0, cycle counter=0.
REQ-034 SHALL discard all FIFO contents when reset is asserted mid-operation; the first store event after reset release is the first entry.

Configuration
REQ-035 SHALL compile the FIFO and log datapath only when STORE_MONITOR_LOG_EN is defined.
REQ-036 SHALL, when STORE_MONITOR_LOG_EN is undefined, tie logValid, logAddr, logData and overflow to 0, ignore logReady, and leave the checker and storeCount unchanged.

Structure
REQ-037 SHALL place the checker state enum, the store_t record typedef {addr[31:0], data[31:0]} and the default parameter constants in the shared package store_monitor_pkg.
REQ-038 SHALL implement the FIFO as the sub-module store_fifo, parameterised by DEPTH and carrying store_t entries.

Verification
REQ-039 SHALL cover the pass case: store (84, 32'h96) at cycle 5 -> pass=1 at cycle 6, fail stays 0, and logAddr=84, logData=32'h96 with logValid=1.
REQ-040 SHALL cover the timeout case: TIMEOUT_CYCLES=20 with no matching store -> fail=1 after cycle 20; a later store (84, 32'h96) leaves pass=0.
REQ-041 SHALL cover overflow: DEPTH=8, logReady=0, 9 stores -> 8 entries retained, overflow=1, storeCount=9; draining returns the first 8 stores in order.
REQ-042 SHALL cover full with simultaneous push and pop: FIFO full, logReady=1 and a store in the same cycle -> overflow stays 0, occupancy stays 8, and the new store is the last entry.
REQ-043 SHALL cover reset mid-run: 3 stores logged, then reset=0 for 2 cycles -> logValid=0, storeCount=0, state=WAIT; the next store becomes the head entry.
REQ-044 SHALL cover the near miss: store (84, 32'h95) then (88, 32'h96) -> pass stays 0, and both stores are logged.

Source files
------------

// File: rtl/store_monitor_pkg.sv
// rtl/store_monitor_pkg.sv - shared types and default constants for the store monitor
package store_monitor_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_PASS    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    localparam int          DEF_DEPTH          = 8;
    localparam logic [31:0] DEF_MATCH_ADDR     = 32'd84;
    localparam logic [31:0] DEF_MATCH_DATA     = 32'h96;
    localparam int          DEF_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - first-word-fall-through FIFO of store_t entries
// Built only when STORE_MONITOR_LOG_EN is defined.
`ifdef STORE_MONITOR_LOG_EN
module store_fifo
    import store_monitor_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  store_t i_data,
    input  logic   i_pop,
    output logic   o_full,
    output logic   o_valid,
    output store_t o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    store_t      r_mem [DEPTH];

    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule
`endif

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - CPU store checker (pass/timeout) with optional store log
// Store log FIFO and overflow flag exist only when STORE_MONITOR_LOG_EN is defined.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int          DEPTH          = DEF_DEPTH,
    parameter logic [31:0] MATCH_ADDR     = DEF_MATCH_ADDR,
    parameter logic [31:0] MATCH_DATA     = DEF_MATCH_DATA,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    output logic        logValid,
    input  logic        logReady,
    output logic [31:0] logAddr,
    output logic [31:0] logData,
    output logic        pass,
    output logic        fail,
    output logic        overflow,
    output logic [15:0] storeCount
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_cycle_cnt;
    logic [15:0] r_store_count;
    logic        w_match;

    assign w_match = memWrite && (dataAddr == MATCH_ADDR) && (writeData == MATCH_DATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_WAIT;
            r_cycle_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_WAIT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    // A match wins over the timeout when both land on the same edge.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT: begin
                if (w_match)                          w_next_state = ST_PASS;
                else if (r_cycle_cnt == TIMEOUT_LAST) w_next_state = ST_TIMEOUT;
            end
            default: w_next_state = r_state;
        endcase
    end

    assign pass = (r_state == ST_PASS);
    assign fail = (r_state == ST_TIMEOUT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     r_store_count <= '0;
        else if (memWrite && r_store_count != 16'hFFFF) r_store_count <= r_store_count + 16'd1;
    end

    assign storeCount = r_store_count;

`ifdef STORE_MONITOR_LOG_EN
    store_t w_in;
    store_t w_head;
    logic   w_full;
    logic   w_valid;
    logic   w_pop;
    logic   r_overflow;

    assign w_in  = '{addr: dataAddr, data: writeData};
    assign w_pop = w_valid && logReady;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (memWrite),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (w_valid),
        .o_data  (w_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               r_overflow <= 1'b0;
        else if (memWrite && w_full && !w_pop)    r_overflow <= 1'b1;
    end

    assign logValid = w_valid;
    assign logAddr  = w_head.addr;
    assign logData  = w_head.data;
    assign overflow = r_overflow;
`else
    logic [$clog2(DEPTH):0] w_unused;
    assign w_unused = {($clog2(DEPTH) + 1){logReady}};

    assign logValid = 1'b0;
    assign logAddr  = '0;
    assign logData  = '0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - directed self-checking bench for store_monitor
module tb_store_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] dataAddr = '0;
    logic [31:0] writeData = '0;
    logic        logReady = 1'b0;
    logic        logValid;
    logic [31:0] logAddr;
    logic [31:0] logData;
    logic        pass;
    logic        fail;
    logic        overflow;
    logic [15:0] storeCount;

`ifdef STORE_MONITOR_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_a [16];
    logic [31:0] exp_d [16];

    store_monitor #(
        .DEPTH          (8),
        .MATCH_ADDR     (32'd84),
        .MATCH_DATA     (32'h96),
        .TIMEOUT_CYCLES (20)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .memWrite   (memWrite),
        .dataAddr   (dataAddr),
        .writeData  (writeData),
        .logValid   (logValid),
        .logReady   (logReady),
        .logAddr    (logAddr),
        .logData    (logData),
        .pass       (pass),
        .fail       (fail),
        .overflow   (overflow),
        .storeCount (storeCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lg(input logic [31:0] v);
        return LOG ? v : 32'd0;
    endfunction

    task automatic tick(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        memWrite  = we;
        dataAddr  = a;
        writeData = d;
        logReady  = rdy;
        @(posedge clk);
        @(negedge clk);
        memWrite = 1'b0;
        logReady = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        memWrite = 1'b0;
        logReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string tag, input int exp_n);
        int n = 0;
        while (logValid && n < 20) begin
            check({tag, "_addr"}, logAddr, exp_a[n]);
            check({tag, "_data"}, logData, exp_d[n]);
            n++;
            tick(1'b0, '0, '0, 1'b1);
        end
        check({tag, "_cnt"}, n, LOG ? exp_n : 0);
    endtask

    initial begin
        #1;
        check("rst_valid", logValid, 0);
        check("rst_addr", logAddr, 0);
        check("rst_data", logData, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_ovf", overflow, 0);
        check("rst_cnt", storeCount, 0);

        // timeout: 20 idle cycles, later match ignored
        do_reset();
        repeat (19) tick(1'b0, '0, '0, 1'b0);
        check("to_fail_early", fail, 0);
        tick(1'b0, '0, '0, 1'b0);
        check("to_fail", fail, 1);
        check("to_pass", pass, 0);
        tick(1'b1, 32'd84, 32'h96, 1'b0);
        tick(1'b0, '0, '0, 1'b0);
        check("to_late_pass", pass, 0);
        check("to_late_fail", fail, 1);
        check("to_cnt", storeCount, 1);

        // pass: matching store at cycle 5
        do_reset();
        repeat (4) tick(1'b0, '0, '0, 1'b0);
        check("pass_early", pass, 0);
        tick(1'b1, 32'd84, 32'h96, 1'b0);
        check("pass", pass, 1);
        check("pass_fail", fail, 0);
        check("pass_valid", logValid, lg(1));
        check("pass_laddr", logAddr, lg(84));
        check("pass_ldata", logData, lg(32'h96));
        check("pass_cnt", storeCount, 1);
        repeat (20) tick(1'b0, '0, '0, 1'b0);
        check("pass_hold", pass, 1);
        check("pass_nofail", fail, 0);

        // overflow: 9 stores into 8 entries
        do_reset();
        for (int i = 0; i < 9; i++) begin
            exp_a[i] = 32'h100 + 32'(4 * i);
            exp_d[i] = 32'hA0 + 32'(i);
            tick(1'b1, exp_a[i], exp_d[i], 1'b0);
        end
        check("ovf_flag", overflow, lg(1));
        check("ovf_cnt", storeCount, 9);
        check("ovf_head", logAddr, lg(32'h100));
        drain("ovf", 8);
        check("ovf_sticky", overflow, lg(1));

        // full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
        for (int i = 0; i < 7; i++) begin
            exp_a[i] = 32'h204 + 32'(4 * i);
            exp_d[i] = 32'hB1 + 32'(i);
        end
        exp_a[7] = 32'h300;
        exp_d[7] = 32'hC0;
        tick(1'b1, 32'h300, 32'hC0, 1'b1);
        check("full_ovf", overflow, 0);
        drain("full", 8);

        // reset mid-run
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h380 + 32'(4 * i), 32'(i), 1'b0);
        do_reset();
        check("mid_valid", logValid, 0);
        check("mid_cnt", storeCount, 0);
        check("mid_pass", pass, 0);
        check("mid_fail", fail, 0);
        tick(1'b1, 32'h400, 32'hD0, 1'b0);
        check("mid_head_a", logAddr, lg(32'h400));
        check("mid_head_d", logData, lg(32'hD0));
        check("mid_cnt1", storeCount, 1);

        // near miss
        do_reset();
        exp_a[0] = 32'd84; exp_d[0] = 32'h95;
        exp_a[1] = 32'd88; exp_d[1] = 32'h96;
        tick(1'b1, exp_a[0], exp_d[0], 1'b0);
        tick(1'b1, exp_a[1], exp_d[1], 1'b0);
        check("near_pass", pass, 0);
        check("near_cnt", storeCount, 2);
        drain("near", 2);
        check("near_pass2", pass, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
